// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide execution unit. A single 2*XLEN-bit
// accumulator is shared by a shift-add multiplier and a restoring divider;
// each operation takes XLEN iterations plus a sign-fix cycle and a done cycle.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   start        - issue request, sampled only while idle
//   funct3       - RV32M operation select (MUL..REMU)
//   rs1_data     - operand A (multiplicand / dividend)
//   rs2_data     - operand B (multiplier / divisor)
//   rd_addr_in   - destination register of the issued op
//   busy         - high whenever an op is in flight (state != IDLE)
//   done         - one-cycle completion pulse
//   rd_addr      - latched destination register
//   rd_wren      - register-file write enable (done and rd_addr != 0)
//   rd_data      - result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_addr,
    output logic            rd_wren,
    output logic [XLEN-1:0] rd_data
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                sign_q;     // negate product / quotient
    logic                sign_r;     // negate remainder (sign of rs1)

    // ---------------- issue-time decode (from input ports) ----------------
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div   = funct3[2];
        // Mul: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
        // Div: even funct3 (DIV/REM) signed, odd (DIVU/REMU) unsigned.
        a_signed = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & rs1_data[XLEN-1];
        b_neg    = b_signed & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = is_div && (rs2_data == '0);
        div_ovf  = is_div && !funct3[0] && (rs1_data == MIN_INT) && (rs2_data == '1);
        special  = div_zero || div_ovf;
        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        if (div_zero) special_res = funct3[1] ? rs1_data : '1;
        else          special_res = funct3[1] ? '0 : MIN_INT;
    end

    // ---------------- one iteration of the shared datapath ----------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        // Shift-add: add multiplicand to the high half when the current
        // multiplier bit (acc LSB) is set, then shift the 65-bit sum right.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        // Restoring division: bring in the next dividend bit, trial-subtract.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!op_q[2])
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        else if (div_diff[XLEN])   // borrow: restore
            acc_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // ---------------- sign fix and result select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = sign_q ? -acc_q : acc_q;
        quo_fix  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sign_r ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        unique case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = special ? DONE : CALC;
            CALC: if (cnt_q == CW'(XLEN-1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from registers only) ----------------
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        rd_wren = done && (rd_addr != '0);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    op_q    <= funct3;
                    a_q     <= a_mag;
                    b_q     <= b_mag;
                    // Low half seeds the multiplier (mul) or dividend (div).
                    acc_q   <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                    sign_q  <= a_neg ^ b_neg;
                    sign_r  <= a_neg;
                    cnt_q   <= '0;
                    rd_addr <= rd_addr_in;
                    if (special) rd_data <= special_res;
                end
                CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX:  rd_data <= fix_res;
                default: ;
            endcase
        end
    end

endmodule
